// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low key matrix scanner with frame debounce, one-hot key code, press strobe and multi-key flag.
// Optional auto-repeat of key_pulse is built when KEYPAD_REPEAT_EN is defined.
module keypad_matrix_scan #(
   parameter int unsigned SCAN_DIV        = 50000,
   parameter int unsigned DEBOUNCE_FRAMES = 5,
   parameter int unsigned REPEAT_DELAY    = 500,
   parameter int unsigned REPEAT_RATE     = 100
) (
   input  logic        clk,
   input  logic        RSTn,
   input  logic [3:0]  col_in,
   output logic [3:0]  row_out,
   output logic [15:0] onehot,
   output logic        key_pulse,
   output logic        multi_key
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam int unsigned DW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CW-1:0] DWELL_MAX = CW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_FRAMES);

   if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("keypad_matrix_scan: illegal parameter value");
   end

   typedef enum logic {ROW_DWELL, FRAME_END} state_t;

   state_t          state, state_nxt;
   logic [3:0]      col_meta, col_sync;
   logic [1:0]      row_idx;
   logic [CW-1:0]   dwell;
   logic [15:0]     raw, cand;
   logic [DW-1:0]   db_cnt, db_cnt_nxt;
   logic            sample, accept, single, press_pulse, repeat_pulse;
   logic [15:0]     new_oh;
   logic            new_multi;

   always_ff @(posedge clk) begin
      if (RSTn) state <= ROW_DWELL;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      sample     = 1'b0;
      accept     = 1'b0;
      db_cnt_nxt = db_cnt;
      case (state)
         ROW_DWELL: begin
            if (dwell == DWELL_MAX) begin
               sample = 1'b1;
               if (row_idx == 2'd3) state_nxt = FRAME_END;
            end
         end
         FRAME_END: begin
            state_nxt = ROW_DWELL;
            if (raw != cand)           db_cnt_nxt = DW'(1);
            else if (db_cnt != DB_MAX) db_cnt_nxt = db_cnt + 1'b1;
            accept = (db_cnt_nxt == DB_MAX);
         end
         default: state_nxt = ROW_DWELL;
      endcase
      // A snapshot is a valid key only if exactly one bit is set.
      single      = (raw != '0) && ((raw & (raw - 16'd1)) == '0);
      new_oh      = single ? raw : '0;
      new_multi   = (raw != '0) && !single;
      press_pulse = accept && (new_oh != '0) && (new_oh != onehot);
   end

   always_ff @(posedge clk) begin
      if (RSTn) begin
         col_meta  <= '1;
         col_sync  <= '1;
         row_idx   <= '0;
         row_out   <= 4'b1110;
         dwell     <= '0;
         raw       <= '0;
         cand      <= '0;
         db_cnt    <= '0;
         onehot    <= '0;
         multi_key <= 1'b0;
         key_pulse <= 1'b0;
      end else begin
         col_meta  <= col_in;
         col_sync  <= col_meta;
         key_pulse <= press_pulse | repeat_pulse;
         db_cnt    <= db_cnt_nxt;
         if (state == ROW_DWELL) begin
            if (sample) begin
               raw[{row_idx, 2'b00} +: 4] <= ~col_sync;
               row_idx <= row_idx + 2'd1;
               row_out <= ~(4'b0001 << (row_idx + 2'd1));
               dwell   <= '0;
            end else begin
               dwell <= dwell + 1'b1;
            end
         end else begin
            cand <= raw;
         end
         if (accept) begin
            onehot    <= new_oh;
            multi_key <= new_multi;
         end
      end
   end

`ifdef KEYPAD_REPEAT_EN
   logic [31:0] rep_cnt;
   logic        rep_phase;
   logic [15:0] oh_nxt;
   logic        hold;

   // rep_phase selects the initial delay (0) or the steady repeat interval (1).
   always_comb begin
      oh_nxt       = accept ? new_oh : onehot;
      hold         = (state == FRAME_END) && (oh_nxt != '0) && (oh_nxt == onehot);
      repeat_pulse = hold && ((rep_cnt + 32'd1) == (rep_phase ? REPEAT_RATE : REPEAT_DELAY));
   end

   always_ff @(posedge clk) begin
      if (RSTn) begin
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
      end else if (state == FRAME_END) begin
         if (!hold) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
         end else if (repeat_pulse) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
         end else begin
            rep_cnt <= rep_cnt + 32'd1;
         end
      end
   end
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Scoreboard bench for keypad_matrix_scan with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (frame = 17 cycles).
module tb_keypad_matrix_scan;

   logic        clk = 1'b0;
   logic        RSTn;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [15:0] onehot;
   logic        key_pulse;
   logic        multi_key;
   logic [15:0] keys;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct packed {
      logic [15:0] oh;
      logic        mk;
      logic        kp;
      logic [31:0] cyc;
   } ev_t;

   ev_t         exp_q[$];
   bit          mon_en = 1'b0;
   logic [15:0] prev_oh;
   logic        prev_mk;

   keypad_matrix_scan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
      .clk      (clk),
      .RSTn     (RSTn),
      .col_in   (col_in),
      .row_out  (row_out),
      .onehot   (onehot),
      .key_pulse(key_pulse),
      .multi_key(multi_key)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Passive matrix: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++)
         if (row_out[r] == 1'b0)
            for (int c = 0; c < 4; c++)
               if (keys[r*4+c]) col_in[c] = 1'b0;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (key_pulse || onehot != prev_oh || multi_key != prev_mk) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_event got oh=%h mk=%b kp=%b cyc=%0d, none expected",
                        onehot, multi_key, key_pulse, cyc);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               if (onehot !== e.oh || multi_key !== e.mk || key_pulse !== e.kp || cyc != int'(e.cyc)) begin
                  n_bad++;
                  $display("FAIL event got oh=%h mk=%b kp=%b cyc=%0d, expected oh=%h mk=%b kp=%b cyc=%0d",
                           onehot, multi_key, key_pulse, cyc, e.oh, e.mk, e.kp, e.cyc);
               end
            end
         end
         prev_oh = onehot;
         prev_mk = multi_key;
      end
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got %h expected %h", name, got, want);
      end
   endtask

   task automatic expect_ev(input logic [15:0] oh, input logic mk, input logic kp, input int at);
      ev_t e;
      e.oh = oh; e.mk = mk; e.kp = kp; e.cyc = 32'(at);
      exp_q.push_back(e);
   endtask

   // Returns on the negedge right after the DUT enters its end-of-frame cycle.
   task automatic wait_frame_start();
      logic [3:0] last;
      bit seen;
      last = row_out;
      seen = 1'b0;
      for (int n = 0; n < 60 && !seen; n++) begin
         @(negedge clk);
         if (last == 4'b0111 && row_out == 4'b1110) seen = 1'b1;
         last = row_out;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL frame_sync got no row wrap within 60 cycles, expected one");
      end
   endtask

   task automatic change_keys(input logic [15:0] k, input bit ev, input logic [15:0] oh,
                              input logic mk, input logic kp);
      wait_frame_start();
      keys = k;
      if (ev) expect_ev(oh, mk, kp, cyc + 52);
   endtask

   task automatic hold_frames(input int n);
      for (int i = 0; i < n; i++) wait_frame_start();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] row_tab [16];
      int cr;
      for (int i = 0; i < 16; i++)
         row_tab[i] = (i < 3) ? 4'b1110 : (i < 7) ? 4'b1101 : (i < 11) ? 4'b1011 :
                      (i < 15) ? 4'b0111 : 4'b1110;

      keys = '0;
      RSTn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_row_out", {12'h0, row_out}, 16'h000E);
      check("reset_onehot", onehot, 16'h0000);
      check("reset_key_pulse", {15'h0, key_pulse}, 16'h0000);
      check("reset_multi_key", {15'h0, multi_key}, 16'h0000);

      RSTn    = 1'b0;
      prev_oh = onehot;
      prev_mk = multi_key;
      mon_en  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check($sformatf("row_seq_%0d", i), {12'h0, row_out}, {12'h0, row_tab[i]});
      end

      // single press (1,2), hold, release
      change_keys(16'h0040, 1'b1, 16'h0040, 1'b0, 1'b1);
      hold_frames(5);
      change_keys(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
      hold_frames(5);

      // bounce on (0,3): six alternating frames, then stable
      for (int i = 0; i < 6; i++) change_keys((i % 2 == 0) ? 16'h0008 : 16'h0000, 1'b0, '0, 1'b0, 1'b0);
      change_keys(16'h0008, 1'b1, 16'h0008, 1'b0, 1'b1);
      hold_frames(5);
      change_keys(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
      hold_frames(5);

      // multi-key (2,0)+(3,3), then release (3,3), then release all
      change_keys(16'h8100, 1'b1, 16'h0000, 1'b1, 1'b0);
      hold_frames(5);
      change_keys(16'h0100, 1'b1, 16'h0100, 1'b0, 1'b1);
      hold_frames(5);
      change_keys(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
      hold_frames(5);

      // key-to-key changes without release
      change_keys(16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1);
      hold_frames(5);
      change_keys(16'h0002, 1'b1, 16'h0002, 1'b0, 1'b1);
      hold_frames(5);
      change_keys(16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1);
      hold_frames(5);

      // reset mid-frame with (0,0) accepted and still held
      wait_frame_start();
      repeat (7) @(negedge clk);
      RSTn = 1'b1;
      expect_ev(16'h0000, 1'b0, 1'b0, cyc + 1);
      @(negedge clk);
      check("midreset_row_out", {12'h0, row_out}, 16'h000E);
      @(negedge clk);
      RSTn = 1'b0;
      cr = cyc;
      expect_ev(16'h0001, 1'b0, 1'b1, cr + 51);
      hold_frames(5);
      change_keys(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
      hold_frames(5);

      for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missing_event got none, expected oh=%h mk=%b kp=%b cyc=%0d", e.oh, e.mk, e.kp, e.cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
